// File: rtl/timer_pkg.sv
// Shared constants and types for the timer_src peripheral: register offsets,
// CTRL layout, interrupt source bit positions and the run/idle state encoding.
package timer_pkg;

  localparam logic [31:0] TMR_CTRL    = 32'd0;
  localparam logic [31:0] TMR_COUNT   = 32'd1;
  localparam logic [31:0] TMR_COMPARE = 32'd2;
  localparam logic [31:0] TMR_PSTAT   = 32'd3;

  localparam int CTRL_EN_BIT         = 0;
  localparam int CTRL_ONESHOT_BIT    = 1;
  localparam int CTRL_AUTORELOAD_BIT = 2;
  localparam int CTRL_PRESC_LSB      = 8;
  localparam int CTRL_PRESC_MSB      = 15;

  localparam int SRC_MATCH = 0;
  localparam int SRC_OVF   = 1;

  typedef struct packed {
    logic [7:0] presc;
    logic [4:0] rsvd;
    logic       autoreload;
    logic       oneshot;
    logic       en;
  } ctrl_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/timer_src_if.sv
// Data-memory bus seen by timer_src: word offset, write strobe/data,
// registered read data and the two interrupt source pulses.
interface timer_src_if #(
  parameter int WIDTH = 32
);
  logic [31:0]      addr;
  logic [WIDTH-1:0] data_w;
  logic             wr_en;
  logic [WIDTH-1:0] data_r;
  logic [1:0]       src;

  modport master (output addr, output data_w, output wr_en, input data_r, input src);
  modport slave  (input addr, input data_w, input wr_en, output data_r, output src);
endinterface

// File: rtl/timer_prescaler.sv
// 8-bit prescaler for timer_src, built only when TIMER_PRESCALER_EN is defined.
// Ticks when the count reaches presc; pcnt_nxt exposes the post-edge count.
module timer_prescaler (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic [7:0] presc,
  input  logic       clr,
  output logic       tick,
  output logic [7:0] pcnt_nxt
);

  logic [7:0] pcnt_r;

  assign tick = en && (pcnt_r == presc);

  // Next prescaler count: clear wins, hold while disabled, else wrap at presc.
  always_comb begin
    pcnt_nxt = pcnt_r;
    if (clr) begin
      pcnt_nxt = 8'd0;
    end else if (!en) begin
      pcnt_nxt = pcnt_r;
    end else if (pcnt_r == presc) begin
      pcnt_nxt = 8'd0;
    end else begin
      pcnt_nxt = pcnt_r + 8'd1;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pcnt_r <= 8'd0;
    end else begin
      pcnt_r <= pcnt_nxt;
    end
  end

endmodule

// File: rtl/timer_src.sv
// Memory-mapped free-running timer producing compare-match / overflow pulses.
// Define TIMER_PRESCALER_EN to build the 8-bit prescaler; otherwise EN ticks every cycle.
module timer_src
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic        clock,
  input logic        reset_n,
  timer_src_if.slave bus
);

  state_t           state_r, state_nxt_s;
  logic             oneshot_r, oneshot_nxt_s;
  logic             autoreload_r, autoreload_nxt_s;
  logic [WIDTH-1:0] count_r, count_nxt_s;
  logic [WIDTH-1:0] compare_r, compare_nxt_s;
  logic [WIDTH-1:0] rdata_r, rdata_nxt_s;
  logic [1:0]       src_r, src_nxt_s;
  logic             wr_ctrl_s, wr_count_s, wr_compare_s;
  logic             en_s, tick_s;
  logic [7:0]       presc_nxt_s, pstat_nxt_s;
  ctrl_t            wr_val_s, ctrl_view_s;

  assign wr_ctrl_s    = bus.wr_en && (bus.addr == TMR_CTRL);
  assign wr_count_s   = bus.wr_en && (bus.addr == TMR_COUNT);
  assign wr_compare_s = bus.wr_en && (bus.addr == TMR_COMPARE);
  assign wr_val_s     = ctrl_t'(bus.data_w[15:0]);
  assign en_s         = (state_r == ST_RUN);

`ifdef TIMER_PRESCALER_EN
  logic [7:0] presc_r;
  logic       unused_ctrl_s;

  assign unused_ctrl_s = ^wr_val_s.rsvd;
  assign presc_nxt_s   = wr_ctrl_s ? wr_val_s.presc : presc_r;

  // Prescale divisor from CTRL[15:8].
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      presc_r <= 8'd0;
    end else begin
      presc_r <= presc_nxt_s;
    end
  end

  timer_prescaler u_prescaler (
    .clock    (clock),
    .reset_n  (reset_n),
    .en       (en_s),
    .presc    (presc_r),
    .clr      (wr_ctrl_s || wr_count_s),
    .tick     (tick_s),
    .pcnt_nxt (pstat_nxt_s)
  );
`else
  logic unused_ctrl_s;

  assign unused_ctrl_s = ^{wr_val_s.rsvd, wr_val_s.presc};
  assign presc_nxt_s   = 8'd0;
  assign pstat_nxt_s   = 8'd0;
  assign tick_s        = en_s;
`endif

  // Tick evaluation on pre-increment COUNT, then bus writes layered on top.
  always_comb begin
    state_nxt_s      = state_r;
    oneshot_nxt_s    = oneshot_r;
    autoreload_nxt_s = autoreload_r;
    count_nxt_s      = count_r;
    compare_nxt_s    = compare_r;
    src_nxt_s        = 2'b00;

    if (tick_s && (count_r == compare_r)) begin
      src_nxt_s[SRC_MATCH] = 1'b1;
      if (autoreload_r) begin
        count_nxt_s = {WIDTH{1'b0}};
      end else begin
        count_nxt_s        = count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        src_nxt_s[SRC_OVF] = &count_r;
      end
      if (oneshot_r) begin
        state_nxt_s = ST_IDLE;
      end else begin
        state_nxt_s = state_r;
      end
    end else if (tick_s) begin
      count_nxt_s        = count_r + {{(WIDTH-1){1'b0}}, 1'b1};
      src_nxt_s[SRC_OVF] = &count_r;
    end else begin
      count_nxt_s = count_r;
    end

    // A COUNT write replaces the whole tick outcome, pulses included.
    if (wr_count_s) begin
      count_nxt_s = bus.data_w;
      src_nxt_s   = 2'b00;
    end else begin
      count_nxt_s = count_nxt_s;
    end

    if (wr_compare_s) begin
      compare_nxt_s = bus.data_w;
    end else begin
      compare_nxt_s = compare_r;
    end

    if (wr_ctrl_s) begin
      state_nxt_s      = wr_val_s.en ? ST_RUN : ST_IDLE;
      oneshot_nxt_s    = wr_val_s.oneshot;
      autoreload_nxt_s = wr_val_s.autoreload;
    end else begin
      oneshot_nxt_s    = oneshot_r;
      autoreload_nxt_s = autoreload_r;
    end
  end

  // Read mux over post-update register values.
  always_comb begin
    ctrl_view_s            = ctrl_t'(16'd0);
    ctrl_view_s.en         = (state_nxt_s == ST_RUN);
    ctrl_view_s.oneshot    = oneshot_nxt_s;
    ctrl_view_s.autoreload = autoreload_nxt_s;
    ctrl_view_s.presc      = presc_nxt_s;
    case (bus.addr)
      TMR_CTRL:    rdata_nxt_s = {{(WIDTH-16){1'b0}}, ctrl_view_s};
      TMR_COUNT:   rdata_nxt_s = count_nxt_s;
      TMR_COMPARE: rdata_nxt_s = compare_nxt_s;
      TMR_PSTAT:   rdata_nxt_s = {{(WIDTH-8){1'b0}}, pstat_nxt_s};
      default:     rdata_nxt_s = {WIDTH{1'b0}};
    endcase
  end

  // Run/idle state, timer registers and registered bus outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      oneshot_r    <= 1'b0;
      autoreload_r <= 1'b0;
      count_r      <= {WIDTH{1'b0}};
      compare_r    <= {WIDTH{1'b0}};
      rdata_r      <= {WIDTH{1'b0}};
      src_r        <= 2'b00;
    end else begin
      state_r      <= state_nxt_s;
      oneshot_r    <= oneshot_nxt_s;
      autoreload_r <= autoreload_nxt_s;
      count_r      <= count_nxt_s;
      compare_r    <= compare_nxt_s;
      rdata_r      <= rdata_nxt_s;
      src_r        <= src_nxt_s;
    end
  end

  assign bus.data_r = rdata_r;
  assign bus.src    = src_r;

endmodule

// File: tb/tb_timer_src.sv
// Scoreboard bench for timer_src: directed bus cycles push expected data_r/src,
// a negedge monitor pops and compares them.
module tb_timer_src;
  import timer_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [1:0]  src;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  timer_src_if #(.WIDTH(32)) bus ();

  timer_src #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compare the head entry against the outputs of the current cycle.
  always @(negedge clock) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      if (sb_q[0].cyc < cyc) begin
        e = sb_q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d was never checked (now %0d)", e.name, e.cyc, cyc);
      end else if (sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        n_tests++;
        if (bus.data_r !== e.data || bus.src !== e.src) begin
          n_fail++;
          $display("FAIL %s: cycle %0d got data_r=%08h src=%02b, want data_r=%08h src=%02b",
                   e.name, cyc, bus.data_r, bus.src, e.data, e.src);
        end
      end
    end
  end

  // One bus cycle: queue the expected post-edge outputs, drive, wait the edge.
  task automatic op(input logic [31:0] a, input logic w, input logic [31:0] d,
                    input logic [31:0] ed, input logic [1:0] es, input string nm);
    exp_t e;
    e.cyc  = cyc + 1;
    e.data = ed;
    e.src  = es;
    e.name = nm;
    sb_q.push_back(e);
    bus.addr   = a;
    bus.wr_en  = w;
    bus.data_w = d;
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] es, input string nm);
    op(a, 1'b0, 32'd0, ed, es, nm);
  endtask

  initial begin
    logic [31:0] exp_d;
    logic [1:0]  exp_s;
    reset_n    = 1'b0;
    bus.addr   = 32'd0;
    bus.wr_en  = 1'b0;
    bus.data_w = 32'd0;

    // Reset held two cycles, with writes that must be ignored.
    op(TMR_CTRL, 1'b1, 32'h0000_0005, 32'd0, 2'b00, "rst_hold_ctrl_wr");
    op(TMR_COUNT, 1'b1, 32'h0000_0007, 32'd0, 2'b00, "rst_hold_count_wr");
    reset_n = 1'b1;
    rd(TMR_CTRL, 32'd0, 2'b00, "rst_ctrl");
    rd(TMR_COUNT, 32'd0, 2'b00, "rst_count");
    rd(TMR_COMPARE, 32'd0, 2'b00, "rst_compare");
    rd(TMR_PSTAT, 32'd0, 2'b00, "rst_pstat");
    op(32'd5, 1'b1, 32'hDEAD_BEEF, 32'd0, 2'b00, "unmapped_wr");
    rd(32'd5, 32'd0, 2'b00, "unmapped_rd");
    rd(TMR_COUNT, 32'd0, 2'b00, "unmapped_no_side_effect");

    // Periodic match with autoreload, COMPARE=3.
    op(TMR_COMPARE, 1'b1, 32'd3, 32'd3, 2'b00, "per_cmp_wr");
    op(TMR_CTRL, 1'b1, 32'h0000_0005, 32'h0000_0005, 2'b00, "per_enable");
    for (int i = 1; i <= 8; i++) begin
      exp_d = 32'(i % 4);
      exp_s = (i % 4 == 0) ? 2'b01 : 2'b00;
      rd(TMR_COUNT, exp_d, exp_s, "per_count");
    end
    op(TMR_CTRL, 1'b1, 32'd0, 32'd0, 2'b00, "per_disable");
    op(TMR_COUNT, 1'b1, 32'd0, 32'd0, 2'b00, "per_count_clr");

    // One-shot, COMPARE=2.
    op(TMR_COMPARE, 1'b1, 32'd2, 32'd2, 2'b00, "os_cmp_wr");
    op(TMR_CTRL, 1'b1, 32'h0000_0003, 32'h0000_0003, 2'b00, "os_enable");
    rd(TMR_COUNT, 32'd1, 2'b00, "os_count1");
    rd(TMR_COUNT, 32'd2, 2'b00, "os_count2");
    rd(TMR_COUNT, 32'd3, 2'b01, "os_match");
    rd(TMR_COUNT, 32'd3, 2'b00, "os_hold1");
    rd(TMR_CTRL, 32'h0000_0002, 2'b00, "os_ctrl_en_cleared");
    rd(TMR_COUNT, 32'd3, 2'b00, "os_hold2");

    // Overflow without match.
    op(TMR_COUNT, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 2'b00, "ovf_count_wr");
    op(TMR_COMPARE, 1'b1, 32'h0000_0010, 32'h0000_0010, 2'b00, "ovf_cmp_wr");
    op(TMR_CTRL, 1'b1, 32'h0000_0001, 32'h0000_0001, 2'b00, "ovf_enable");
    rd(TMR_COUNT, 32'hFFFF_FFFF, 2'b00, "ovf_allones");
    rd(TMR_COUNT, 32'd0, 2'b10, "ovf_wrap");
    rd(TMR_COUNT, 32'd1, 2'b00, "ovf_after");
    op(TMR_CTRL, 1'b1, 32'd0, 32'd0, 2'b00, "ovf_disable");
    rd(TMR_COUNT, 32'd2, 2'b00, "ovf_stopped");

    // Match and overflow on the same tick.
    op(TMR_COUNT, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 2'b00, "both_count_wr");
    op(TMR_COMPARE, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, "both_cmp_wr");
    op(TMR_CTRL, 1'b1, 32'h0000_0001, 32'h0000_0001, 2'b00, "both_enable");
    rd(TMR_COUNT, 32'hFFFF_FFFF, 2'b00, "both_allones");
    rd(TMR_COUNT, 32'd0, 2'b11, "both_pulse");
    op(TMR_CTRL, 1'b1, 32'd0, 32'd0, 2'b00, "both_disable");
    rd(TMR_COUNT, 32'd1, 2'b00, "both_stopped");

    // Prescaled autoreload, PRESC=3, COMPARE=1.
    op(TMR_COUNT, 1'b1, 32'd0, 32'd0, 2'b00, "psc_count_clr");
    op(TMR_COMPARE, 1'b1, 32'd1, 32'd1, 2'b00, "psc_cmp_wr");
`ifdef TIMER_PRESCALER_EN
    op(TMR_CTRL, 1'b1, 32'h0000_0305, 32'h0000_0305, 2'b00, "psc_enable");
    for (int i = 1; i <= 16; i++) begin
      exp_d = 32'(i % 4);
      exp_s = (i % 8 == 0) ? 2'b01 : 2'b00;
      rd(TMR_PSTAT, exp_d, exp_s, "psc_pstat");
    end
    op(TMR_CTRL, 1'b1, 32'd0, 32'd0, 2'b00, "psc_disable");
    rd(TMR_COUNT, 32'd0, 2'b00, "psc_count_end");
`else
    op(TMR_CTRL, 1'b1, 32'h0000_0305, 32'h0000_0005, 2'b00, "psc_enable");
    for (int i = 1; i <= 16; i++) begin
      exp_s = (i % 2 == 0) ? 2'b01 : 2'b00;
      rd(TMR_PSTAT, 32'd0, exp_s, "psc_pstat");
    end
    op(TMR_CTRL, 1'b1, 32'd0, 32'd0, 2'b00, "psc_disable");
    rd(TMR_COUNT, 32'd1, 2'b00, "psc_count_end");
`endif

    // Reset in the middle of a run.
    op(TMR_COUNT, 1'b1, 32'd0, 32'd0, 2'b00, "mid_count_clr");
    op(TMR_COMPARE, 1'b1, 32'd100, 32'd100, 2'b00, "mid_cmp_wr");
    op(TMR_CTRL, 1'b1, 32'h0000_0005, 32'h0000_0005, 2'b00, "mid_enable");
    for (int i = 1; i <= 5; i++) begin
      rd(TMR_COUNT, 32'(i), 2'b00, "mid_count");
    end
    reset_n = 1'b0;
    rd(TMR_COUNT, 32'd0, 2'b00, "mid_reset");
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd(TMR_COUNT, 32'd0, 2'b00, "mid_post_count");
    end
    rd(TMR_CTRL, 32'd0, 2'b00, "mid_post_ctrl");
    rd(TMR_COMPARE, 32'd0, 2'b00, "mid_post_compare");

    bus.wr_en = 1'b0;
    repeat (3) @(posedge clock);
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
